// File: rtl/shift_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// shift_arbiter_pkg
//   Shared definitions for the shared barrel-shifter arbiter:
//   - shift opcode encodings used by ALU decode, multdiv and the shifter
//   - the request record carried through the operand stage (S1)
//   - the mapping from the ALU shift function field to a shift opcode
// -----------------------------------------------------------------------------
package shift_arbiter_pkg;

    // Shift opcode encodings
    localparam logic SHIFT_OP_SLL = 1'b0;
    localparam logic SHIFT_OP_SRA = 1'b1;

    // ALU shift function field values as decoded in the execute stage
    localparam logic [1:0] ALU_FN_SLL = 2'b00;
    localparam logic [1:0] ALU_FN_SRA = 2'b11;

    // One request as captured in the operand register
    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic        op;
        logic        id;
    } shift_req_t;

    // Map an ALU shift function field to the shifter opcode; anything that is
    // not an arithmetic right shift falls back to a logical left shift.
    function automatic logic alu_fn_to_shift_op(input logic [1:0] alu_fn);
        logic op;
        case (alu_fn)
            ALU_FN_SLL: op = SHIFT_OP_SLL;
            ALU_FN_SRA: op = SHIFT_OP_SRA;
            default:    op = SHIFT_OP_SLL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/shift_arbiter_core.sv
// -----------------------------------------------------------------------------
// shift_arbiter_core
//   Combinational 32-bit shifter: a logical-left stage and an arithmetic-right
//   stage, with the result selected on the opcode.
// Ports
//   a_i       in  32  operand
//   shamt_i   in  5   shift amount (0 passes the operand unchanged)
//   op_i      in  1   SHIFT_OP_SLL / SHIFT_OP_SRA
//   result_o  out 32  shifted operand
// -----------------------------------------------------------------------------
module shift_arbiter_core
    import shift_arbiter_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [4:0]  shamt_i,
    input  logic        op_i,
    output logic [31:0] result_o
);

    logic [31:0] sll_s;
    logic [31:0] sra_s;

    // Left shift fills with zeros; right shift replicates bit 31.
    assign sll_s = a_i << shamt_i;
    assign sra_s = $unsigned($signed(a_i) >>> shamt_i);

    // Result select on opcode
    always_comb begin
        result_o = sll_s;
        case (op_i)
            SHIFT_OP_SRA: result_o = sra_s;
            SHIFT_OP_SLL: result_o = sll_s;
            default:      result_o = sll_s;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//   Shares one barrel shifter between the ALU execute stage (port 0) and the
//   multdiv unit (port 1). Round-robin arbitration on contention, a two-stage
//   pipeline (S1 operand register, S2 result register) with full throughput,
//   and a saturating count of accepted requests.
// Ports
//   clock, reset             clock; synchronous active-high reset
//   reqN_valid/ready         request handshake (ready = accepted this cycle)
//   reqN_a/shamt/op          operand, shift amount, opcode (0 SLL, 1 SRA)
//   res_valid/ready          result handshake
//   res_data/res_id          shifted value and the port that issued it
//   busy                     S1 or S2 holds a valid entry
//   op_count                 accepted requests since reset, saturating
// -----------------------------------------------------------------------------
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter logic RR_INIT = 1'b1,
    parameter int   CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [4:0]       req0_shamt,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [4:0]       req1_shamt,
    input  logic             req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid_q, s1_valid_d;
    shift_req_t       s1_q, s1_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             grant_s;
    logic             accept_s;
    shift_req_t       req_s;
    logic [31:0]      shift_res_s;

    // S2 can take a new entry when empty or when its result leaves this cycle;
    // S1 can then take one when empty or moving into S2.
    assign s2_adv_s = ~s2_valid_q | res_ready;
    assign s1_adv_s = ~s1_valid_q | s2_adv_s;

    // Round-robin grant: a lone requester wins, contention goes to the port
    // that did not win the last accepted request.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid & req1_valid) begin
            grant_s = ~last_grant_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Readies are held low during reset so nothing is accepted into a pipe
    // that is being cleared.
    assign req0_ready = ~reset & s1_adv_s & ~grant_s & req0_valid;
    assign req1_ready = ~reset & s1_adv_s &  grant_s & req1_valid;
    assign accept_s   = req0_ready | req1_ready;

    // Request record of the granted port
    always_comb begin
        req_s = '{a: req0_a, shamt: req0_shamt, op: req0_op, id: 1'b0};
        if (grant_s) begin
            req_s = '{a: req1_a, shamt: req1_shamt, op: req1_op, id: 1'b1};
        end else begin
            req_s = '{a: req0_a, shamt: req0_shamt, op: req0_op, id: 1'b0};
        end
    end

    shift_arbiter_core u_core (
        .a_i      (s1_q.a),
        .shamt_i  (s1_q.shamt),
        .op_i     (s1_q.op),
        .result_o (shift_res_s)
    );

    // Next-state for pipeline stages, round-robin pointer and counter
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_d         = s1_q;
        s2_valid_d   = s2_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        op_count_d   = op_count_q;

        if (s1_adv_s) begin
            s1_valid_d = accept_s;
            if (accept_s) begin
                s1_d = req_s;
            end else begin
                s1_d = s1_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        // Result payload only loads with a real entry so a stalled output
        // never changes under the consumer.
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_data_d = shift_res_s;
                res_id_d   = s1_q.id;
            end else begin
                res_data_d = res_data_q;
                res_id_d   = res_id_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end

        if (accept_s) begin
            last_grant_d = grant_s;
            if (op_count_q != {CNT_W{1'b1}}) begin
                op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                op_count_d = op_count_q;
            end
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // State registers with synchronous reset; in-flight entries are dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            s2_valid_q   <= 1'b0;
            res_data_q   <= 32'h0000_0000;
            res_id_q     <= 1'b0;
            last_grant_q <= RR_INIT;
            op_count_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_q         <= s1_d;
            s2_valid_q   <= s2_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
            op_count_q   <= op_count_d;
        end
    end

    assign res_valid = s2_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = s1_valid_q | s2_valid_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = 32'h0, req1_a = 32'h0;
    logic [4:0]  req0_shamt = 5'd0, req1_shamt = 5'd0;
    logic        req0_op = 1'b0, req1_op = 1'b0;
    logic        res_valid, res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_id, busy;
    logic [15:0] op_count;

    // Second instance with a tiny counter for saturation
    logic        b_v0 = 1'b0;
    logic        b_r0, b_r1, b_res_valid, b_res_id, b_busy;
    logic [31:0] b_res_data;
    logic [1:0]  b_op_count;

    always #5 clock = ~clock;

    shift_arbiter #(.RR_INIT(1'b1), .CNT_W(16)) u_dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_shamt(req0_shamt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_shamt(req1_shamt), .req1_op(req1_op),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy), .op_count(op_count)
    );

    shift_arbiter #(.RR_INIT(1'b1), .CNT_W(2)) u_dut_sat (
        .clock(clock), .reset(reset),
        .req0_valid(b_v0), .req0_ready(b_r0), .req0_a(32'h0000_0001),
        .req0_shamt(5'd1), .req0_op(1'b0),
        .req1_valid(1'b0), .req1_ready(b_r1), .req1_a(32'h0000_0000),
        .req1_shamt(5'd0), .req1_op(1'b0),
        .res_valid(b_res_valid), .res_ready(1'b1), .res_data(b_res_data),
        .res_id(b_res_id), .busy(b_busy), .op_count(b_op_count)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          acc_cnt = 0;
    logic [32:0] sb_q[$];
    logic [32:0] log_q[$];
    logic [32:0] tmp;
    int          p0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference shifter built from single-bit steps
    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s, input logic op);
        logic [31:0] r;
        r = a;
        for (int k = 0; k < 32; k++) begin
            if (k < int'(s)) r = op ? {r[31], r[31:1]} : {r[30:0], 1'b0};
        end
        return r;
    endfunction

    // One clock: record accepts, check/consume results, then check stall hold
    task automatic step();
        logic        stalled;
        logic        in_reset;
        logic [31:0] pdata;
        logic        pid;
        #1;
        check("one_ready", {31'b0, req0_ready & req1_ready}, 32'h0);
        if (req0_ready === 1'b1) begin
            sb_q.push_back({1'b0, model(req0_a, req0_shamt, req0_op)});
            acc_cnt++;
        end
        if (req1_ready === 1'b1) begin
            sb_q.push_back({1'b1, model(req1_a, req1_shamt, req1_op)});
            acc_cnt++;
        end
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            check("result_expected", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                tmp = sb_q.pop_front();
                check("res_data", res_data, tmp[31:0]);
                check("res_id", {31'b0, res_id}, {31'b0, tmp[32]});
                log_q.push_back({res_id, res_data});
            end
        end
        stalled  = res_valid & ~res_ready;
        in_reset = reset;
        pdata    = res_data;
        pid      = res_id;
        @(posedge clock);
        #1;
        if (stalled && !in_reset) begin
            check("hold_valid", {31'b0, res_valid}, 32'd1);
            check("hold_data", res_data, pdata);
            check("hold_id", {31'b0, res_id}, {31'b0, pid});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        sb_q.delete();
        log_q.delete();
        acc_cnt = 0;
    endtask

    initial begin
        // Reset state; a request during reset must not be accepted
        req0_valid = 1'b1;
        step();
        check("rst_ready0", {31'b0, req0_ready}, 32'd0);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_op_count", {16'b0, op_count}, 32'd0);
        check("rst_res_data", res_data, 32'h0);
        check("rst_res_id", {31'b0, res_id}, 32'd0);
        do_reset();

        // 1) single port 0 SRA
        req0_valid = 1'b1; req0_a = 32'h8000_00F0; req0_shamt = 5'd4; req0_op = 1'b1;
        res_ready = 1'b1;
        #1;
        check("t1_ready0", {31'b0, req0_ready}, 32'd1);
        check("t1_ready1", {31'b0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        check("t1_lat_valid", {31'b0, res_valid}, 32'd0);
        check("t1_busy", {31'b0, busy}, 32'd1);
        step();
        check("t1_res_valid", {31'b0, res_valid}, 32'd1);
        check("t1_res_data", res_data, 32'hF800_000F);
        check("t1_res_id", {31'b0, res_id}, 32'd0);
        step();
        check("t1_idle", {31'b0, busy}, 32'd0);
        check("t1_count", {16'b0, op_count}, 32'd1);

        // 2) contention: grants alternate 0,1,0,1
        do_reset();
        req0_valid = 1'b1; req0_a = 32'h1; req0_op = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_shamt = 5'd31; req1_op = 1'b1;
        p0 = 0;
        for (int i = 0; i < 4; i++) begin
            req0_shamt = 5'(p0);
            #1;
            check("t2_grant0", {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_grant1", {31'b0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 0) p0++;
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();
        check("t2_nres", log_q.size(), 32'd4);
        if (log_q.size() == 4) begin
            check("t2_r0", log_q[0][31:0], 32'h0000_0001);
            check("t2_r1", log_q[1][31:0], 32'hFFFF_FFFF);
            check("t2_r2", log_q[2][31:0], 32'h0000_0002);
            check("t2_r3", log_q[3][31:0], 32'hFFFF_FFFF);
            check("t2_ids", {28'b0, log_q[0][32], log_q[1][32], log_q[2][32], log_q[3][32]}, 32'h5);
        end
        check("t2_count", {16'b0, op_count}, 32'd4);

        // 3) backpressure with both ports streaming
        do_reset();
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h0000_00F0; req0_shamt = 5'd4; req0_op = 1'b0;
        req1_valid = 1'b1; req1_a = 32'hF000_0000; req1_shamt = 5'd8; req1_op = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i < 2) begin
                check("t3_accept", {31'b0, req0_ready | req1_ready}, 32'd1);
            end else begin
                check("t3_full_r0", {31'b0, req0_ready}, 32'd0);
                check("t3_full_r1", {31'b0, req1_ready}, 32'd0);
                check("t3_stall_valid", {31'b0, res_valid}, 32'd1);
                check("t3_stall_data", res_data, 32'h0000_0F00);
            end
            step();
        end
        res_ready = 1'b1;
        repeat (4) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();
        check("t3_drained", sb_q.size(), 32'd0);
        check("t3_count", {16'b0, op_count}, acc_cnt);
        check("t3_first", log_q[0][31:0], 32'h0000_0F00);
        check("t3_second", log_q[1][31:0], 32'hFFF0_0000);
        check("t3_second_id", {31'b0, log_q[1][32]}, 32'd1);

        // 4) res_ready toggling under continuous port 1 traffic
        do_reset();
        req1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req1_a = 32'h1234_5678 ^ (32'h0F0F_3C3C * i);
            req1_shamt = 5'((i * 3) % 32);
            req1_op = i[0];
            res_ready = ~i[0];
            step();
        end
        req1_valid = 1'b0; res_ready = 1'b1;
        repeat (4) step();
        check("t4_accepts", acc_cnt, 32'd7);
        check("t4_count", {16'b0, op_count}, 32'd7);
        check("t4_emitted", log_q.size(), 32'd7);
        check("t4_drained", sb_q.size(), 32'd0);

        // 5) reset with S1 and S2 both full
        do_reset();
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'hDEAD_BEEF; req0_shamt = 5'd1; req0_op = 1'b0;
        step();
        step();
        check("t5_full_busy", {31'b0, busy}, 32'd1);
        check("t5_full_valid", {31'b0, res_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_ready", {31'b0, req0_ready}, 32'd0);
        step();
        reset = 1'b0; req0_valid = 1'b0;
        sb_q.delete(); acc_cnt = 0;
        check("t5_res_valid", {31'b0, res_valid}, 32'd0);
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_count", {16'b0, op_count}, 32'd0);
        check("t5_data", res_data, 32'h0);
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_stale", {31'b0, res_valid}, 32'd0);
        end

        // 6) saturating 2-bit counter
        b_v0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t6_sat", {30'b0, b_op_count}, (k < 3) ? 32'(k + 1) : 32'd3);
        end
        b_v0 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
